effect_processor: RTL and testbench

Stereo audio effect stage between the I2S receiver and transmitter. Accepts one frame (left + right sample) per `i_valid` strobe and applies one of four modes: bypass, mute, fixed-point gain, or feed-forward echo from an on-chip delay line. Produces the result with a fixed two-cycle latency and a matching `o_valid` strobe. It is the parametrised successor of the pass-through effect controller and keeps the same data-width parameter and signed sample format.

---
 rtl/effect_pkg.sv | 40 ++++
 rtl/effect_delay_ram.sv | 33 +++
 rtl/effect_processor.sv | 167 ++++++++++++++++
 tb/tb_effect_processor.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/effect_pkg.sv
// Shared types, default widths and the saturation helper for the effect stage.
package effect_pkg;

  typedef enum logic [1:0] {
    BYPASS = 2'b00,
    MUTE   = 2'b01,
    GAIN   = 2'b10,
    ECHO   = 2'b11
  } effect_mode_t;

  localparam int DEF_D_WIDTH     = 24;
  localparam int DEF_DELAY_DEPTH = 4096;
  localparam int DEF_GAIN_W      = 8;
  localparam int DEF_GAIN_FRAC   = 6;

  // Clamp a signed value held in the low in_w bits of x to the signed range
  // of out_w bits. The result is returned sign-extended to 64 bits; callers
  // take the low out_w bits. Both widths must be compile-time constants at
  // the call site so this folds into plain comparators.
  function automatic logic signed [63:0] sat_signed(
    input logic signed [63:0] x,
    input int                 in_w,
    input int                 out_w
  );
    logic signed [63:0] xe;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    xe = (x <<< (64 - in_w)) >>> (64 - in_w);
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_w - 1));
    if (xe > hi) begin
      sat_signed = hi;
    end else if (xe < lo) begin
      sat_signed = lo;
    end else begin
      sat_signed = xe;
    end
  endfunction

endpackage

// File: rtl/effect_delay_ram.sv
// Simple dual-port delay-line RAM: one write port, one registered read port.
// Contents are deliberately not reset so the array maps onto block RAM.
module effect_delay_ram #(
  parameter int DATA_W = 48,
  parameter int DEPTH  = 4096,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write port: store the frame at the write pointer.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read port: synchronous read, data holds until the next read enable.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/effect_processor.sv
// Stereo effect stage: bypass / mute / gain / echo with a two-cycle pipeline.
//
// Handshake: there is no back-pressure. i_valid is a one-cycle strobe that
// qualifies the data, mode, gain and delay inputs on the edge where it is
// sampled high. A strobe that arrives while stage 2 is busy (the edge right
// after an accepted frame) is dropped and latched into the sticky o_overrun.
// o_valid is a one-cycle strobe that qualifies o_l_data/o_r_data; the data
// outputs hold their last value between strobes.
module effect_processor
  import effect_pkg::*;
#(
  parameter int  D_WIDTH     = DEF_D_WIDTH,
  parameter int  DELAY_DEPTH = DEF_DELAY_DEPTH,
  parameter int  GAIN_W      = DEF_GAIN_W,
  parameter int  GAIN_FRAC   = DEF_GAIN_FRAC,
  localparam int ADDR_W      = $clog2(DELAY_DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_valid,
  input  logic [D_WIDTH-1:0] i_l_data,
  input  logic [D_WIDTH-1:0] i_r_data,
  input  logic [1:0]         i_mode,
  input  logic [GAIN_W-1:0]  i_gain,
  input  logic [ADDR_W-1:0]  i_delay,
  output logic               o_valid,
  output logic [D_WIDTH-1:0] o_l_data,
  output logic [D_WIDTH-1:0] o_r_data,
  output logic               o_overrun
);

  localparam int PROD_W = D_WIDTH + GAIN_W + 1;
  localparam int SUM_W  = D_WIDTH + 1;
  localparam int FILL_W = ADDR_W + 1;

  logic                      accept;
  logic                      drop;
  logic                      s1_valid;
  logic signed [D_WIDTH-1:0] s1_l;
  logic signed [D_WIDTH-1:0] s1_r;
  effect_mode_t              s1_mode;
  logic [GAIN_W-1:0]         s1_gain;
  logic                      s1_echo_ok;
  logic [ADDR_W-1:0]         wr_ptr;
  logic [ADDR_W-1:0]         rd_addr;
  logic [FILL_W-1:0]         fill;
  logic [FILL_W-1:0]         eff_delay;
  logic [2*D_WIDTH-1:0]      rd_data;
  logic signed [D_WIDTH-1:0] d_l;
  logic signed [D_WIDTH-1:0] d_r;
  logic signed [D_WIDTH-1:0] y_l;
  logic signed [D_WIDTH-1:0] y_r;

  // One channel of the effect arithmetic. use_d gates the delayed sample so
  // RAM slots that were never written since reset stay silent.
  function automatic logic signed [D_WIDTH-1:0] process_chan(
    input logic signed [D_WIDTH-1:0] x,
    input logic signed [D_WIDTH-1:0] d,
    input effect_mode_t              m,
    input logic [GAIN_W-1:0]         g,
    input logic                      use_d
  );
    logic signed [PROD_W-1:0]  prod;
    logic signed [SUM_W-1:0]   sum;
    logic signed [D_WIDTH-1:0] d_eff;
    prod  = PROD_W'(x) * PROD_W'($signed({1'b0, g}));
    d_eff = use_d ? d : '0;
    sum   = SUM_W'(x) + SUM_W'(d_eff >>> 1);
    case (m)
      BYPASS:  process_chan = x;
      MUTE:    process_chan = '0;
      GAIN:    process_chan = D_WIDTH'(sat_signed(64'(prod >>> GAIN_FRAC), PROD_W, D_WIDTH));
      ECHO:    process_chan = D_WIDTH'(sat_signed(64'(sum), SUM_W, D_WIDTH));
      default: process_chan = x;
    endcase
  endfunction

  // Stage 2 is busy exactly when stage 1 holds a frame.
  assign accept = i_valid && !s1_valid;
  assign drop   = i_valid && s1_valid;

  // A delay field of zero selects the full depth; the read then lands on the
  // slot that stage 2 is about to overwrite, i.e. the oldest stored frame.
  assign eff_delay = (i_delay == '0) ? FILL_W'(DELAY_DEPTH) : {1'b0, i_delay};
  assign rd_addr   = wr_ptr - eff_delay[ADDR_W-1:0];

  assign d_l = $signed(rd_data[2*D_WIDTH-1:D_WIDTH]);
  assign d_r = $signed(rd_data[D_WIDTH-1:0]);

  assign y_l = process_chan(s1_l, d_l, s1_mode, s1_gain, s1_echo_ok);
  assign y_r = process_chan(s1_r, d_r, s1_mode, s1_gain, s1_echo_ok);

  effect_delay_ram #(
    .DATA_W (2 * D_WIDTH),
    .DEPTH  (DELAY_DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (s1_valid),
    .wr_addr (wr_ptr),
    .wr_data ({s1_l, s1_r}),
    .rd_en   (accept),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // Stage 1: snapshot the frame and its controls; decide whether history
  // deep enough for the requested delay already exists.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1_l       <= '0;
      s1_r       <= '0;
      s1_mode    <= BYPASS;
      s1_gain    <= '0;
      s1_echo_ok <= 1'b0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_l       <= $signed(i_l_data);
        s1_r       <= $signed(i_r_data);
        s1_mode    <= effect_mode_t'(i_mode);
        s1_gain    <= i_gain;
        s1_echo_ok <= (eff_delay <= fill);
      end
    end
  end

  // Delay-line bookkeeping: advance the write pointer and the saturating
  // fill count once per frame written in stage 2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      fill   <= '0;
    end else if (s1_valid) begin
      wr_ptr <= wr_ptr + ADDR_W'(1);
      if (fill != FILL_W'(DELAY_DEPTH)) begin
        fill <= fill + FILL_W'(1);
      end
    end
  end

  // Stage 2: register the processed frame and pulse o_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_valid  <= 1'b0;
      o_l_data <= '0;
      o_r_data <= '0;
    end else begin
      o_valid <= s1_valid;
      if (s1_valid) begin
        o_l_data <= y_l;
        o_r_data <= y_r;
      end
    end
  end

  // Sticky overrun: any strobe arriving while stage 2 is busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_overrun <= 1'b0;
    end else if (drop) begin
      o_overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_effect_processor.sv
// Self-checking bench for effect_processor (small delay line for wrap tests).
module tb_effect_processor;

  localparam int DW    = 24;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int GW    = 8;

  logic          clk;
  logic          rst_n;
  logic          i_valid;
  logic [DW-1:0] i_l_data;
  logic [DW-1:0] i_r_data;
  logic [1:0]    i_mode;
  logic [GW-1:0] i_gain;
  logic [AW-1:0] i_delay;
  logic          o_valid;
  logic [DW-1:0] o_l_data;
  logic [DW-1:0] o_r_data;
  logic          o_overrun;

  int n_checks = 0;
  int n_fail   = 0;

  // Every accepted input frame since the last reset, oldest first.
  longint hist_l[$];
  longint hist_r[$];

  effect_processor #(
    .D_WIDTH     (DW),
    .DELAY_DEPTH (DEPTH),
    .GAIN_W      (GW),
    .GAIN_FRAC   (6)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_valid   (i_valid),
    .i_l_data  (i_l_data),
    .i_r_data  (i_r_data),
    .i_mode    (i_mode),
    .i_gain    (i_gain),
    .i_delay   (i_delay),
    .o_valid   (o_valid),
    .o_l_data  (o_l_data),
    .o_r_data  (o_r_data),
    .o_overrun (o_overrun)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checkers ----------------
  task automatic check_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %b required %b", name, act, exp);
    end
  endtask

  task automatic check_data(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic longint sx(input logic [DW-1:0] v);
    return longint'($signed(v));
  endfunction

  function automatic longint floor_div(input longint a, input longint b);
    longint q;
    q = a / b;
    if ((a % b != 0) && ((a < 0) != (b < 0))) q = q - 1;
    return q;
  endfunction

  function automatic longint clamp(input longint v);
    if (v > 8388607) return 8388607;
    if (v < -8388608) return -8388608;
    return v;
  endfunction

  // Delayed sample for the given delay field, or 0 if history is too short.
  function automatic longint tap(input longint h[$], input logic [AW-1:0] dly);
    int eff;
    eff = (dly == 0) ? DEPTH : int'(dly);
    if (h.size() >= eff) return h[h.size() - eff];
    return 0;
  endfunction

  function automatic logic [DW-1:0] model_chan(input logic [DW-1:0] xv, input longint d,
                                               input logic [1:0] mode, input logic [GW-1:0] gain);
    longint x;
    longint y;
    x = sx(xv);
    case (mode)
      2'b00:   y = x;
      2'b01:   y = 0;
      2'b10:   y = clamp(floor_div(x * longint'(gain), 64));
      default: y = clamp(x + floor_div(d, 2));
    endcase
    return DW'(y);
  endfunction

  // ---------------- drivers ----------------
  // Called at a negedge. Drives one frame for the next posedge, scrambles the
  // inputs afterwards, then checks the two-edge latency and the output data.
  // Returns at the negedge where the output was checked, so back-to-back
  // calls give the minimum two-cycle spacing.
  task automatic send_frame(input logic [DW-1:0] l, input logic [DW-1:0] r,
                            input logic [1:0] mode, input logic [GW-1:0] gain,
                            input logic [AW-1:0] dly, input logic [DW-1:0] el,
                            input logic [DW-1:0] er, input string name);
    i_valid  = 1'b1;
    i_l_data = l;
    i_r_data = r;
    i_mode   = mode;
    i_gain   = gain;
    i_delay  = dly;
    hist_l.push_back(sx(l));
    hist_r.push_back(sx(r));
    @(negedge clk);
    i_valid  = 1'b0;
    i_l_data = DW'($urandom());
    i_r_data = DW'($urandom());
    i_mode   = 2'($urandom());
    i_gain   = GW'($urandom());
    i_delay  = AW'($urandom());
    check_bit({name, " valid_early"}, o_valid, 1'b0);
    @(negedge clk);
    check_bit({name, " valid"}, o_valid, 1'b1);
    check_data({name, " left"}, o_l_data, el);
    check_data({name, " right"}, o_r_data, er);
  endtask

  task automatic model_send(input logic [DW-1:0] l, input logic [DW-1:0] r,
                            input logic [1:0] mode, input logic [GW-1:0] gain,
                            input logic [AW-1:0] dly, input string name);
    logic [DW-1:0] el;
    logic [DW-1:0] er;
    el = model_chan(l, tap(hist_l, dly), mode, gain);
    er = model_chan(r, tap(hist_r, dly), mode, gain);
    send_frame(l, r, mode, gain, dly, el, er, name);
  endtask

  task automatic do_reset();
    @(negedge clk);
    i_valid = 1'b0;
    rst_n   = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    hist_l.delete();
    hist_r.delete();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [DW-1:0] l;
    logic [DW-1:0] r;
    logic [1:0]    mode;
    logic [GW-1:0] gain;
    logic [DW-1:0] el;
    logic [DW-1:0] er;
    string         name;
  } vec_t;

  vec_t vecs[8];

  // ---------------- test sequence ----------------
  initial begin
    rst_n    = 1'b0;
    i_valid  = 1'b0;
    i_l_data = '0;
    i_r_data = '0;
    i_mode   = 2'b00;
    i_gain   = '0;
    i_delay  = '0;

    vecs[0] = '{24'h123456, 24'hFEDCBA, 2'b00, 8'h00, 24'h123456, 24'hFEDCBA, "bypass"};
    vecs[1] = '{24'h500000, 24'hB00000, 2'b10, 8'h80, 24'h7FFFFF, 24'h800000, "gain2_sat"};
    vecs[2] = '{24'h300000, 24'hD00000, 2'b10, 8'h80, 24'h600000, 24'hA00000, "gain2"};
    vecs[3] = '{24'h000010, 24'hFFFFF0, 2'b10, 8'h20, 24'h000008, 24'hFFFFF8, "gain_half"};
    vecs[4] = '{24'h7FFFFF, 24'h800000, 2'b10, 8'h40, 24'h7FFFFF, 24'h800000, "gain_unity"};
    vecs[5] = '{24'hFFFFFF, 24'h000001, 2'b10, 8'h01, 24'hFFFFFF, 24'h000000, "gain_floor"};
    vecs[6] = '{24'h123456, 24'hFEDCBA, 2'b01, 8'h40, 24'h000000, 24'h000000, "mute"};
    vecs[7] = '{24'h000040, 24'h400000, 2'b10, 8'hFF, 24'h0000FF, 24'h7FFFFF, "gain_max"};

    // Reset state.
    repeat (3) @(negedge clk);
    check_bit("rst o_valid", o_valid, 1'b0);
    check_data("rst o_l_data", o_l_data, '0);
    check_data("rst o_r_data", o_r_data, '0);
    check_bit("rst o_overrun", o_overrun, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table: fixed-value frames, each followed by an idle hold check.
    for (int i = 0; i < 8; i++) begin
      send_frame(vecs[i].l, vecs[i].r, vecs[i].mode, vecs[i].gain, '0,
                 vecs[i].el, vecs[i].er, vecs[i].name);
      @(negedge clk);
      check_bit({vecs[i].name, " hold_valid"}, o_valid, 1'b0);
      check_data({vecs[i].name, " hold_left"}, o_l_data, vecs[i].el);
      check_data({vecs[i].name, " hold_right"}, o_r_data, vecs[i].er);
    end
    check_bit("table overrun", o_overrun, 1'b0);

    // Random frames in all modes against the model.
    for (int n = 0; n < 80; n++) begin
      logic [DW-1:0] l;
      logic [DW-1:0] r;
      int sel;
      sel = $urandom_range(0, 5);
      l = (sel == 0) ? 24'h7FFFFF : (sel == 1) ? 24'h800000 : DW'($urandom());
      r = DW'($urandom());
      model_send(l, r, 2'($urandom_range(0, 3)), GW'($urandom_range(0, 255)),
                 AW'($urandom_range(0, DEPTH - 1)), "random");
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    check_bit("random overrun", o_overrun, 1'b0);

    // Echo impulse, delay 3, frames 4 cycles apart. RAM holds stale data
    // from the random run, which must stay silent until history fills.
    do_reset();
    begin
      logic [DW-1:0] imp_in[5];
      logic [DW-1:0] imp_out[5];
      imp_in  = '{24'h100000, 24'h0, 24'h0, 24'h0, 24'h0};
      imp_out = '{24'h100000, 24'h0, 24'h0, 24'h080000, 24'h0};
      for (int k = 0; k < 5; k++) begin
        send_frame(imp_in[k], imp_in[k], 2'b11, 8'h00, 4'd3, imp_out[k], imp_out[k], "echo_imp");
        repeat (2) @(negedge clk);
      end
    end

    // Echo wrap: delay 0 means full depth, ramp input.
    do_reset();
    for (int n = 0; n < 40; n++) begin
      int e;
      e = (n < DEPTH) ? n : n + (n - DEPTH) / 2;
      send_frame(DW'(n), DW'(n), 2'b11, 8'h00, 4'd0, DW'(e), DW'(e), "echo_wrap");
    end

    // Overrun: strobe on consecutive cycles, the second is dropped.
    do_reset();
    @(negedge clk);
    i_valid  = 1'b1;
    i_l_data = 24'h000111;
    i_r_data = 24'h000111;
    i_mode   = 2'b11;
    i_gain   = 8'h00;
    i_delay  = 4'd1;
    hist_l.push_back(sx(24'h000111));
    hist_r.push_back(sx(24'h000111));
    @(negedge clk);
    i_l_data = 24'h000222;
    i_r_data = 24'h000222;
    @(negedge clk);
    i_valid = 1'b0;
    check_bit("ovr valid", o_valid, 1'b1);
    check_data("ovr left", o_l_data, 24'h000111);
    check_bit("ovr flag", o_overrun, 1'b1);
    @(negedge clk);
    check_bit("ovr single_valid", o_valid, 1'b0);
    // Next frame echoes the accepted one, proving the drop wrote nothing.
    model_send(24'h000000, 24'h000000, 2'b11, 8'h00, 4'd1, "ovr_next");
    check_data("ovr echo_of_kept", o_l_data, 24'h000088);
    check_bit("ovr sticky", o_overrun, 1'b1);

    // Reset the cycle after an accept: frame aborted, flag cleared.
    @(negedge clk);
    i_valid  = 1'b1;
    i_l_data = 24'h345678;
    i_r_data = 24'h345678;
    i_mode   = 2'b00;
    i_delay  = 4'd1;
    @(negedge clk);
    i_valid = 1'b0;
    rst_n   = 1'b0;
    @(negedge clk);
    check_bit("abort valid", o_valid, 1'b0);
    check_data("abort left", o_l_data, '0);
    check_data("abort right", o_r_data, '0);
    check_bit("abort overrun", o_overrun, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    hist_l.delete();
    hist_r.delete();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_bit("abort no_valid", o_valid, 1'b0);
    end
    // Aborted frame must not be in history: first echo is dry only.
    model_send(24'h000100, 24'hFFFF00, 2'b11, 8'h00, 4'd1, "post_abort1");
    model_send(24'h000000, 24'h000000, 2'b11, 8'h00, 4'd1, "post_abort2");
    check_data("post_abort echo", o_l_data, 24'h000080);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

endmodule
